// File: rtl/xs3_serial_adder_pkg.sv
// Shared constants, state encoding and code-range helper for the XS3 serial adder.
package xs3_pkg;

  localparam logic [3:0] XS3_MIN  = 4'd3;
  localparam logic [3:0] XS3_MAX  = 4'd12;
  localparam logic [3:0] XS3_ZERO = 4'b0011;
  localparam logic [3:0] XS3_CORR = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_e;

  // True when a nibble is not one of the ten legal XS3 digit codes.
  function automatic logic xs3_bad(input logic [3:0] code);
    return (code < XS3_MIN) || (code > XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_serial_adder_if.sv
// Digit-pair input stream and sum-digit output stream of the XS3 serial adder.
interface xs3_serial_adder_if;
  logic [3:0] a_xs3;
  logic [3:0] b_xs3;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] s_xs3;
  logic       s_valid;
  logic       s_last;
  logic       s_carry;
  logic       s_err;
  logic       out_ready;

  modport slave (
    input  a_xs3, b_xs3, in_valid, in_last, out_ready,
    output in_ready, s_xs3, s_valid, s_last, s_carry, s_err
  );

  modport master (
    output a_xs3, b_xs3, in_valid, in_last, out_ready,
    input  in_ready, s_xs3, s_valid, s_last, s_carry, s_err
  );
endinterface

// File: rtl/xs3_serial_adder_digit_add.sv
// One XS3 digit-pair addition with carry in/out and illegal-code detection.
module xs3_digit_add
  import xs3_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       bad_code
);

  logic [4:0] sum5;

  // Binary add, then correct the excess: +3 when a decimal carry left the digit, -3 otherwise.
  always_comb begin
    sum5     = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    cout     = sum5[4];
    digit    = sum5[4] ? (sum5[3:0] + XS3_CORR) : (sum5[3:0] - XS3_CORR);
    bad_code = xs3_bad(a) || xs3_bad(b);
  end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial XS3 adder: LSD-first digit pairs in, registered XS3 sum digits out.
module xs3_serial_adder
  import xs3_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  xs3_serial_adder_if.slave io
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e          state_q, state_d;
  logic            cy_q, cy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [3:0]      s_xs3_q, s_xs3_d;
  logic            s_valid_q, s_valid_d;
  logic            s_last_q, s_last_d;
  logic            s_carry_q, s_carry_d;
  logic            s_err_q, s_err_d;

  logic            accept;
  logic            cin;
  logic [3:0]      digit;
  logic            cout;
  logic            bad_code;
  logic            overrun;
  logic            err_cur;

  assign io.in_ready = !s_valid_q || io.out_ready;
  assign accept      = io.in_valid && io.in_ready;

  // A frame always starts from zero carry, even if cy_q were somehow left set.
  assign cin = (state_q == FRAME) ? cy_q : 1'b0;

  xs3_digit_add u_add (
    .a        (io.a_xs3),
    .b        (io.b_xs3),
    .cin      (cin),
    .digit    (digit),
    .cout     (cout),
    .bad_code (bad_code)
  );

  // Any pair accepted once MAX_DIGITS pairs are already in makes the frame too long,
  // including when that pair is flagged last.
  assign overrun = (cnt_q == CW'(MAX_DIGITS));
  assign err_cur = err_q || bad_code || overrun;

  // Frame tracking: carry, saturating digit count and sticky error; cleared on a last digit.
  always_comb begin
    state_d = state_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      if (io.in_last) begin
        state_d = IDLE;
        cy_d    = 1'b0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        state_d = FRAME;
        cy_d    = cout;
        cnt_d   = overrun ? cnt_q : cnt_q + CW'(1);
        err_d   = err_cur;
      end
    end
  end

  // Output register: loads on accept, drops valid once the digit is taken, else holds.
  always_comb begin
    s_xs3_d   = s_xs3_q;
    s_valid_d = s_valid_q;
    s_last_d  = s_last_q;
    s_carry_d = s_carry_q;
    s_err_d   = s_err_q;
    if (accept) begin
      s_xs3_d   = digit;
      s_valid_d = 1'b1;
      s_last_d  = io.in_last;
      s_carry_d = io.in_last ? cout : 1'b0;
      s_err_d   = err_cur;
    end else if (io.out_ready) begin
      s_valid_d = 1'b0;
    end
  end

  // State and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_xs3_q   <= XS3_ZERO;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      s_carry_q <= 1'b0;
      s_err_q   <= 1'b0;
    end else begin
      s_xs3_q   <= s_xs3_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      s_carry_q <= s_carry_d;
      s_err_q   <= s_err_d;
    end
  end

  assign io.s_xs3   = s_xs3_q;
  assign io.s_valid = s_valid_q;
  assign io.s_last  = s_last_q;
  assign io.s_carry = s_carry_q;
  assign io.s_err   = s_err_q;

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Directed, table-driven bench for the XS3 serial adder.
module tb_xs3_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   emits;

  xs3_serial_adder_if bus ();

  xs3_serial_adder #(.MAX_DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.s_valid && bus.out_ready) emits <= emits + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       last;
    logic [3:0] s;
    logic       carry;
    logic       err;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Present one pair, wait (bounded) until it is taken, and leave time #1 after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int n;
    bus.a_xs3    = a;
    bus.b_xs3    = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("accept_timeout", 8'd0, 8'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [3:0] s, input logic last,
                         input logic carry, input logic err);
    chk({name, "_valid"}, {7'd0, bus.s_valid}, 8'd1);
    chk({name, "_s"},     {4'd0, bus.s_xs3},   {4'd0, s});
    chk({name, "_last"},  {7'd0, bus.s_last},  {7'd0, last});
    chk({name, "_carry"}, {7'd0, bus.s_carry}, {7'd0, carry});
    chk({name, "_err"},   {7'd0, bus.s_err},   {7'd0, err});
  endtask

  initial begin
    checks = 0; errors = 0; emits = 0;
    //          a        b        last  s        cy    err
    tbl[0]  = '{4'b1000, 4'b1000, 1'b1, 4'b0011, 1'b1, 1'b0}; // 5+5
    tbl[1]  = '{4'b1100, 4'b0100, 1'b0, 4'b0011, 1'b0, 1'b0}; // 999+001
    tbl[2]  = '{4'b1100, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[3]  = '{4'b1100, 4'b0011, 1'b1, 4'b0011, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b1}; // bad A on digit 1
    tbl[5]  = '{4'b1000, 4'b1000, 1'b0, 4'b0100, 1'b0, 1'b1};
    tbl[6]  = '{4'b0011, 4'b0011, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 4'b0101, 1'b0, 1'b0}; // 1+1 clean
    tbl[8]  = '{4'b1010, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b0}; // 7+8
    tbl[9]  = '{4'b0111, 4'b0110, 1'b1, 4'b1010, 1'b0, 1'b0}; // 4+3
    tbl[10] = '{4'b0000, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b1}; // bad A below range
    tbl[11] = '{4'b0011, 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0};
    tbl[12] = '{4'b0011, 4'b1101, 1'b1, 4'b0011, 1'b1, 1'b1}; // bad B above range
    tbl[13] = '{4'b1100, 4'b1100, 1'b1, 4'b1011, 1'b1, 1'b0}; // 9+9

    bus.a_xs3 = 4'b0011; bus.b_xs3 = 4'b0011;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, bus.s_valid}, 8'd0);
    chk("rst_s",     {4'd0, bus.s_xs3},   8'h03);
    chk("rst_last",  {7'd0, bus.s_last},  8'd0);
    chk("rst_carry", {7'd0, bus.s_carry}, 8'd0);
    chk("rst_err",   {7'd0, bus.s_err},   8'd0);
    chk("rst_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last);
      chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].last, tbl[i].carry, tbl[i].err);
    end
    @(posedge clk); #1;
    chk("idle_valid", {7'd0, bus.s_valid}, 8'd0);

    // Backpressure: hold out_ready low for 4 cycles with the next pair waiting.
    emits = 0;
    send(4'b0100, 4'b0100, 1'b0);
    chk_out("bp_d1", 4'b0101, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.a_xs3 = 4'b0101; bus.b_xs3 = 4'b0101; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", {7'd0, bus.in_ready}, 8'd0);
      chk("bp_hold",  {3'd0, bus.s_valid, bus.s_xs3}, 8'h15);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_out("bp_d2", 4'b0111, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 4'b0110, 1'b1);
    chk_out("bp_d3", 4'b1001, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp_emits", emits[7:0], 8'd3);

    // Overrun: nine 0+0 digits, last only on the ninth.
    for (int i = 0; i < 9; i++) begin
      send(4'b0011, 4'b0011, (i == 8));
      chk_out($sformatf("ovr%0d", i), 4'b0011, (i == 8), 1'b0, (i == 8));
    end
    send(4'b0011, 4'b0011, 1'b1);
    chk_out("ovr_next", 4'b0011, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame with a carry pending.
    send(4'b1100, 4'b0100, 1'b0);
    chk_out("rm_d1", 4'b0011, 1'b0, 1'b0, 1'b0);
    send(4'b1100, 4'b1100, 1'b0);
    chk_out("rm_d2", 4'b1100, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", {7'd0, bus.s_valid}, 8'd0);
    chk("rm_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(4'b0011, 4'b0011, 1'b1);
    chk_out("rm_next", 4'b0011, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
